cover_toggle_collector: RTL and testbench
=========================================

COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

Interface
REQ-001 SHALL have parameter NUM_POINTS, default 64: number of toggle cover points fed in, 1..1024.
REQ-002 SHALL have parameter BASE_INDEX, default 0: global cover index of point 0.
REQ-003 SHALL have parameter IDX_W, default 16: width of emitted cover index.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries, power of two, >=2.
REQ-005 SHALL have port clock, input, 1: sole clock, all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset; state resets at the clock edge where reset==0.
REQ-007 SHALL have port enable, input, 1: hits are sampled only when 1.
REQ-008 SHALL have port hit, input, NUM_POINTS: per-point toggle-event pulse vector (the per-point valid signals).
REQ-009 SHALL have port clear, input, 1: synchronous clear of all coverage state.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts out_index.
REQ-011 SHALL have port out_valid, output, 1: out_index holds a newly covered point.
REQ-012 SHALL have port out_index, output, IDX_W: BASE_INDEX + point number, truncated to IDX_W.
REQ-013 SHALL have port covered_count, output, clog2(NUM_POINTS+1): number of distinct points covered.
REQ-014 SHALL have port all_covered, output, 1: covered_count == NUM_POINTS.
REQ-015 SHALL have port busy, output, 1: any pending bit set or FIFO non-empty.

Function
REQ-016 SHALL keep a sticky covered bitmap; new = hit & ~covered & {NUM_POINTS{enable}}, sampled each edge.
REQ-017 SHALL set covered and pending bits for every new point at the edge sampling them; repeat hits on covered points are ignored.
REQ-018 SHALL increment covered_count by popcount(new) at that same edge; multiple points per cycle allowed.
REQ-019 SHALL, each edge, select the lowest-numbered pending bit, push it into the FIFO and clear it, provided FIFO not full or a pop occurs that same edge.
REQ-020 SHALL NOT push a point into the FIFO in the edge that sets its pending bit; hit-to-out_valid latency with empty FIFO is exactly 2 edges.
REQ-021 SHALL pop the FIFO head when out_valid && out_ready; out_valid == FIFO non-empty; out_index stable while out_valid && !out_ready.
REQ-022 SHALL support simultaneous push and pop when full, occupancy unchanged.
REQ-023 SHALL never drop a hit: pending bits hold back-pressured points indefinitely.
REQ-024 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH with an extra wrap bit distinguishing full from empty.
REQ-025 SHALL, on clear==1, zero covered, pending, FIFO, covered_count at that edge; hits, pushes and pops in that cycle are discarded.
REQ-026 SHALL give reset priority over clear, and clear priority over hit/push/pop.
REQ-027 SHALL drive all_covered and busy combinationally from registered state.

Reset
REQ-028 SHALL, at an edge with reset==0, set covered=0, pending=0, FIFO empty, covered_count=0.
REQ-029 SHALL hold out_valid=0, all_covered=0, busy=0 in the first cycle after reset release.
REQ-030 SHALL discard in-flight entries if reset asserts mid-operation; no stale index emitted afterwards.

Verification (NUM_POINTS=8, BASE_INDEX=100, FIFO_DEPTH=4)
REQ-031 SHALL test: enable=1, hit=8'h04 for one cycle, out_ready=1 -> out_valid high exactly 2 edges later with out_index=102 for one cycle; covered_count=1.
REQ-032 SHALL test: hit=8'h04 repeated 5 cycles -> only one out_index=102 emitted; covered_count stays 1.
REQ-033 SHALL test: hit=8'hFF one cycle, out_ready=0 -> FIFO fills with 100,101,102,103, pending holds 104..107, busy=1; then out_ready=1 -> indices 100..107 in order, no gaps, covered_count=8, all_covered=1.
REQ-034 SHALL test: enable=0 with hit=8'hFF -> no output, covered_count=0.
REQ-035 SHALL test: FIFO holding 3 entries, clear=1 with hit=8'h01 same cycle -> next cycle out_valid=0, busy=0, covered_count=0; a later hit=8'h01 emits 100 again.
REQ-036 SHALL test: reset=0 for one edge while FIFO full and pending nonzero -> all outputs 0 afterwards, no stale index emitted.

Source files
------------

// File: rtl/cover_toggle_collector.sv
//------------------------------------------------------------------------------
// Module      : cover_toggle_collector
// Description : Sticky toggle-coverage bitmap that reports each newly covered
//               point once, lowest-numbered first, through a small output FIFO.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cover_toggle_collector #(
   parameter int NUM_POINTS = 64,
   parameter int BASE_INDEX = 0,
   parameter int IDX_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              enable,
   input  logic [NUM_POINTS-1:0]             hit,
   input  logic                              clear,
   input  logic                              out_ready,
   output logic                              out_valid,
   output logic [IDX_W-1:0]                  out_index,
   output logic [$clog2(NUM_POINTS+1)-1:0]   covered_count,
   output logic                              all_covered,
   output logic                              busy
);

   localparam int CNT_W = $clog2(NUM_POINTS + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [NUM_POINTS-1:0] covered_q, covered_d;
   logic [NUM_POINTS-1:0] pending_q, pending_d;
   logic [NUM_POINTS-1:0] new_pts;
   logic [NUM_POINTS-1:0] sel_oh;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [CNT_W-1:0]      new_cnt;
   logic [AW:0]           wr_ptr_q, wr_ptr_d;
   logic [AW:0]           rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0]      fifo_q [FIFO_DEPTH];
   logic [IDX_W-1:0]      fifo_d [FIFO_DEPTH];
   logic [IDX_W-1:0]      sel_idx;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  do_pop;
   logic                  do_push;

   always_comb begin
      new_pts = hit & ~covered_q & {NUM_POINTS{enable}};
      // Isolate the lowest set pending bit; pushes only ever see last cycle's pending.
      sel_oh  = pending_q & (~pending_q + NUM_POINTS'(1));
      sel_idx = '0;
      new_cnt = '0;
      for (int i = 0; i < NUM_POINTS; i++) begin
         if (sel_oh[i]) begin
            sel_idx = IDX_W'(BASE_INDEX + i);
         end
         new_cnt = new_cnt + CNT_W'(new_pts[i]);
      end

      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop     = !fifo_empty && out_ready;
      do_push    = (|pending_q) && (!fifo_full || do_pop);

      covered_d = covered_q | new_pts;
      pending_d = (pending_q & ~(sel_oh & {NUM_POINTS{do_push}})) | new_pts;
      count_d   = count_q + new_cnt;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fifo_d   = fifo_q;
      if (do_push) begin
         wr_ptr_d                  = wr_ptr_q + PTR_ONE;
         fifo_d[wr_ptr_q[AW-1:0]]  = sel_idx;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         covered_q <= '0;
         pending_q <= '0;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         covered_q <= covered_d;
         pending_q <= pending_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only visible between the pointers.
   always_ff @(posedge clock) begin
      fifo_q <= fifo_d;
   end

   assign out_valid     = !fifo_empty;
   assign out_index     = fifo_q[rd_ptr_q[AW-1:0]];
   assign covered_count = count_q;
   assign all_covered   = (count_q == CNT_W'(NUM_POINTS));
   assign busy          = (|pending_q) || !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_cover_toggle_collector.sv
//------------------------------------------------------------------------------
// Module      : tb_cover_toggle_collector
// Description : Randomised and directed self-checking bench with a set/queue
//               reference model of the coverage collector.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cover_toggle_collector;

   localparam int NP   = 8;
   localparam int BASE = 100;
   localparam int DEP  = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          enable;
   logic [NP-1:0] hit;
   logic          clear;
   logic          out_ready;
   logic          out_valid;
   logic [15:0]   out_index;
   logic [3:0]    covered_count;
   logic          all_covered;
   logic          busy;

   cover_toggle_collector #(
      .NUM_POINTS (NP),
      .BASE_INDEX (BASE),
      .IDX_W      (16),
      .FIFO_DEPTH (DEP)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .hit           (hit),
      .clear         (clear),
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .out_index     (out_index),
      .covered_count (covered_count),
      .all_covered   (all_covered),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: a set of covered points, a set of waiting points and a
   // queue of indices already handed to the output buffer.
   bit m_cov  [NP];
   bit m_pend [NP];
   int m_fifo [$];
   int m_cnt;
   bit m_live = 0;
   int dut_log [$];

   function automatic bit m_any_pend();
      for (int i = 0; i < NP; i++) if (m_pend[i]) return 1;
      return 0;
   endfunction

   always @(posedge clock) begin
      if (reset && !clear && out_valid && out_ready)
         dut_log.push_back(int'(out_index));
      if (!reset || clear) begin
         for (int i = 0; i < NP; i++) begin m_cov[i] = 0; m_pend[i] = 0; end
         m_fifo.delete();
         m_cnt  = 0;
         m_live = 1;
      end else if (m_live) begin
         bit pop;
         int lowest;
         pop    = (m_fifo.size() > 0) && out_ready;
         lowest = -1;
         for (int i = 0; i < NP; i++) if (m_pend[i] && lowest < 0) lowest = i;
         if (pop) void'(m_fifo.pop_front());
         if (lowest >= 0 && (m_fifo.size() < DEP)) begin
            m_fifo.push_back(BASE + lowest);
            m_pend[lowest] = 0;
         end
         for (int i = 0; i < NP; i++) begin
            if (enable && hit[i] && !m_cov[i]) begin
               m_cov[i]  = 1;
               m_pend[i] = 1;
               m_cnt++;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (m_live) begin
         check("out_valid", int'(out_valid), int'(m_fifo.size() > 0));
         if (m_fifo.size() > 0) check("out_index", int'(out_index), m_fifo[0]);
         check("covered_count", int'(covered_count), m_cnt);
         check("all_covered", int'(all_covered), int'(m_cnt == NP));
         check("busy", int'(busy), int'(m_any_pend() || m_fifo.size() > 0));
      end
   end

   task automatic drive(input logic [NP-1:0] h, input logic en, input logic rdy,
                        input logic clr, input logic rst_n);
      #1;
      hit = h; enable = en; out_ready = rdy; clear = clr; reset = rst_n;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 0; enable = 0; hit = '0; clear = 0; out_ready = 0;
      tick(2);
      drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_all_covered", int'(all_covered), 0);
      check("rst_count", int'(covered_count), 0);

      // Single hit: visible two edges later, for one cycle.
      drive(8'h04, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(1);
      check("lat_edge1_valid", int'(out_valid), 0);
      drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(1);
      check("lat_edge2_valid", int'(out_valid), 1);
      check("lat_edge2_index", int'(out_index), 102);
      tick(1);
      check("lat_edge3_valid", int'(out_valid), 0);
      check("lat_count", int'(covered_count), 1);

      // Repeated hit on one point emits only once.
      drive(8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(1);
      dut_log.delete();
      drive(8'h04, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(5);
      drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(3);
      check("repeat_log_size", dut_log.size(), 1);
      if (dut_log.size() > 0) check("repeat_log_idx", dut_log[0], 102);
      check("repeat_count", int'(covered_count), 1);

      // Burst of all points with back-pressure, then drain in order.
      drive(8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      tick(1);
      dut_log.delete();
      drive(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(1);
      drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(8);
      check("burst_busy", int'(busy), 1);
      check("burst_head", int'(out_index), 100);
      check("burst_count", int'(covered_count), 8);
      check("burst_all", int'(all_covered), 1);
      drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(14);
      check("burst_log_size", dut_log.size(), 8);
      for (int i = 0; i < dut_log.size() && i < 8; i++)
         check("burst_order", dut_log[i], 100 + i);
      check("burst_idle", int'(busy), 0);

      // Disabled sampling.
      drive(8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(1);
      drive(8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(4);
      check("dis_valid", int'(out_valid), 0);
      check("dis_count", int'(covered_count), 0);

      // Clear beats a simultaneous hit while the FIFO holds three entries.
      drive(8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      tick(1);
      drive(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(1);
      drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(3);
      check("clr_pre_count", int'(covered_count), 3);
      drive(8'h01, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(1);
      check("clr_valid", int'(out_valid), 0);
      check("clr_busy", int'(busy), 0);
      check("clr_count", int'(covered_count), 0);
      drive(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(1);
      drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(1);
      check("clr_again_valid", int'(out_valid), 1);
      check("clr_again_index", int'(out_index), 100);

      // Reset mid-operation with a full FIFO and pending points.
      drive(8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      tick(1);
      drive(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(1);
      drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(6);
      drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      tick(1);
      dut_log.delete();
      drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(1);
      check("mrst_valid", int'(out_valid), 0);
      check("mrst_busy", int'(busy), 0);
      check("mrst_count", int'(covered_count), 0);
      check("mrst_all", int'(all_covered), 0);
      tick(6);
      check("mrst_no_stale", dut_log.size(), 0);

      // Randomised traffic against the model.
      for (int c = 0; c < 500; c++) begin
         logic [NP-1:0] h;
         h = NP'($urandom) & NP'($urandom) & NP'($urandom);
         drive(h, ($urandom_range(0, 9) != 0), ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 59) == 0), ($urandom_range(0, 149) != 0));
         tick(1);
      end
      drive(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(20);
      check("final_idle", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
